seq_det_arb: RTL

SEQ_DET_ARB -- requirements
Module: seq_det_arb

---
 rtl/seq_det_arb_pkg.sv | 20 ++
 rtl/seq_det_rr_arb.sv | 36 +++
 rtl/seq_det_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_det_arb_pkg.sv
// Shared types and constants for the sequence-detector serial-line arbiter.
package seq_det_arb_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned SHIFT_LEN = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BIT_CNT_W = $clog2(SHIFT_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

  // Saturating increment for the per-requester hit statistics.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module seq_det_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W:0] cand;

  // Scan from the farthest offset down so the closest valid requester wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      cand = (ID_W+1)'(ptr_i) + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (valid_i[cand[ID_W-1:0]]) begin
        idx_o = cand[ID_W-1:0];
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_arb.sv
// Round-robin arbiter serialising requester bytes onto one sequence-detector line.
// Optional per-requester hit statistics enabled by SEQ_DET_ARB_STATS_EN.
module seq_det_arb
  import seq_det_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ser_data,
  input  logic                      seq_detected,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_hit,
  output logic                      busy
`ifdef SEQ_DET_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  hit_cnt
`endif
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SHIFT_LEN - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shreg_q, shreg_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic                 ser_q, ser_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_hit_q, rsp_hit_d;

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [BYTE_W-1:0]    gnt_byte;

  seq_det_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // Byte of the requester currently being granted.
  always_comb begin
    gnt_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        gnt_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      cur_id_q    <= '0;
      ser_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cur_id_q    <= cur_id_d;
      ser_q       <= ser_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  // Bit 0 is loaded at the grant edge so the registered line shows it in the first SHIFT cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cur_id_d    = cur_id_q;
    ser_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_hit_d   = rsp_hit_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          req_ready = gnt_oh;
          shreg_d   = {1'b0, gnt_byte[BYTE_W-1:1]};
          ser_d     = gnt_byte[0];
          cur_id_d  = gnt_idx;
          rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_SAMPLE;
        end else begin
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      ST_SAMPLE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = cur_id_q;
        rsp_hit_d   = seq_detected;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      req_ready = '0;
    end
  end

  assign ser_data  = ser_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_hit   = rsp_hit_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SEQ_DET_ARB_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q [NUM_REQ];

  // Count hit responses per owning requester, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hit_cnt_q[i] <= '0;
      end
    end else if (rsp_valid_q && rsp_hit_q) begin
      hit_cnt_q[rsp_id_q] <= sat_inc(hit_cnt_q[rsp_id_q]);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit_cnt
    assign hit_cnt[gi*CNT_W +: CNT_W] = hit_cnt_q[gi];
  end
`endif

endmodule
